mem_stage_sram: RTL and testbench
=================================

Name: mem_stage_sram

Overview:
- MEM-stage block; consumes the EXE/MEM pipeline register outputs (ALU result as address, Rm value as store data, MEM_W/MEM_R).
- Performs 32-bit loads/stores on an external 16-bit SRAM as two half-word accesses with programmable wait states.
- Drops `ready` while a transaction is in flight so the pipeline freezes.
- Load data goes to the MEM/WB register via `mem_result`.

Parameters:
- BASE_ADDR, 1024: CPU byte address that maps to SRAM word 0.
- SRAM_ADDR_W, 18: SRAM half-word address width.
- WAIT_CYCLES, 1: extra cycles each half-word phase is held; 0 to 7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_r_en  in  1  load request, from the EXE/MEM register.
- mem_w_en  in  1  store request, from the EXE/MEM register.
- alu_res  in  32  byte address.
- val_rm  in  32  store data.
- ready  out  1  0 = freeze the pipeline.
- mem_result  out  32  last completed load word.
- sram_addr  out  SRAM_ADDR_W  half-word address.
- sram_dq_out  out  16  write data.
- sram_dq_in  in  16  read data.
- sram_dq_oe  out  1  1 = drive the DQ bus (writes).
- sram_we_n  out  1  active-low write enable.

Behaviour:
- Reset values: FSM in IDLE, counter 0, ready=1 (no request), mem_result=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address mapping: word = (alu_res - BASE_ADDR) >> 2. Low half-word is at {word[SRAM_ADDR_W-2:0],1'b0}; high half-word is at {word[SRAM_ADDR_W-2:0],1'b1}. alu_res[1:0] is ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If (mem_r_en|mem_w_en), latch the address, val_rm and the operation (write wins if both are set), clear the counter, and go to LOW.
  - ready = ~(mem_r_en|mem_w_en), combinational.
- LOW:
  - sram_addr = low address.
  - Write: sram_dq_oe=1, sram_we_n=0, sram_dq_out=data[15:0].
  - Counter increments each cycle.
  - When counter==WAIT_CYCLES: on a read, capture sram_dq_in into the low half; clear the counter and go to HIGH.
- HIGH: same as LOW but uses the high address and data[31:16], then goes to DONE.
- DONE:
  - ready=1, sram_we_n=1, sram_dq_oe=0.
  - On a read, mem_result = {high, low}, registered on the HIGH→DONE edge so it is valid throughout DONE.
  - Next state IDLE unconditionally.
- Timing: ready is low for 2*WAIT_CYCLES+3 cycles, then high for exactly one cycle (DONE). The pipeline advances on that edge. With WAIT_CYCLES=1: 5 stall cycles.
- Request inputs are ignored outside IDLE. Dropping a request mid-transaction does not abort it.
- mem_result holds its value across stores and idle cycles, and updates only on load completion.
- A back-to-back request arriving in the cycle after DONE starts a fresh transaction from IDLE.
- sram_we_n is never low while sram_dq_oe=0.
- Reset mid-transaction returns to IDLE with all reset values; any partial write is not completed.

Optional Feature:
- Macro MEM_RANGE_CHECK_EN.
- Defined:
  - A request whose alu_res < BASE_ADDR or whose word ≥ 2^(SRAM_ADDR_W-1) issues no SRAM access.
  - The FSM goes IDLE→DONE, so ready is low for one cycle.
  - mem_result is unchanged.
  - Adds output `addr_err` (1 bit), sticky until rst.
- Not defined: no check, no `addr_err` port; the address wraps modulo the SRAM size.

Decomposition:
- Package ca_mem_pkg: FSM state enum, default BASE_ADDR, and the half-word width constant 16.
- One natural sub-module, sram_wait_counter: clear/enable counter with terminal flag at WAIT_CYCLES.

Test Plan:
- Store 0x12345678 to alu_res=1024, WAIT_CYCLES=1:
  - SRAM[0]=0x5678 then SRAM[1]=0x1234, each we_n low for 2 cycles.
  - ready low for 5 cycles, high for 1.
- Load from 1024 after that store: mem_result=0x12345678 in the DONE cycle; it stays 0x12345678 through a following store to 1028.
- Load from 1028 with SRAM[2]=0xBEEF, SRAM[3]=0xCAFE: sram_addr sequence 2,2,3,3; mem_result=0xCAFEBEEF.
- Assert rst during the HIGH phase of a store: we_n=1, oe=0, ready=1, mem_result=0 immediately; SRAM[3] unchanged.
- Sweep WAIT_CYCLES=0 and 3: stall length 3 and 9 cycles; mem_w_en and mem_r_en both set → performs a write.
- With MEM_RANGE_CHECK_EN, store to alu_res=512: no we_n pulse, one stall cycle, addr_err=1 until rst.

Source files
------------

// File: rtl/ca_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM bridge.
package ca_mem_pkg;

    localparam int unsigned DEFAULT_BASE_ADDR = 32'd1024;
    localparam int          HALF_W            = 16;
    localparam int          CNT_W             = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait-state counter; tc flags the last cycle of a half-word phase.
module sram_wait_counter
    import ca_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/mem_stage_sram.sv
// MEM stage: 32-bit load/store as two 16-bit SRAM accesses with wait states.
// Optional MEM_RANGE_CHECK_EN rejects out-of-window addresses and adds sticky addr_err.
module mem_stage_sram
    import ca_mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SRAM_ADDR_W = 18,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            alu_res,
    input  logic [31:0]            val_rm,
    output logic                   ready,
    output logic [31:0]            mem_result,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [HALF_W-1:0]      sram_dq_out,
    input  logic [HALF_W-1:0]      sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic                   addr_err
`endif
);

    localparam int WORD_W = SRAM_ADDR_W - 1;

    mem_state_e        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [31:0]       data_q, data_d;
    logic              wr_q, wr_d;
    logic [HALF_W-1:0] low_q, low_d;
    logic [31:0]       result_q, result_d;

    logic        req;
    logic        in_range;
    logic        in_phase;
    logic        tc;
    logic [31:0] offset;
    logic [29:0] word_full;
    logic        unused_offset;

    assign req           = mem_r_en | mem_w_en;
    assign offset        = alu_res - 32'(BASE_ADDR);
    assign word_full     = offset[31:2];
    assign unused_offset = ^offset;
    assign in_phase      = (state_q == ST_LOW) || (state_q == ST_HIGH);

`ifdef MEM_RANGE_CHECK_EN
    logic err_q, err_d;
    assign in_range = (alu_res >= 32'(BASE_ADDR)) && ((word_full >> WORD_W) == '0);
    assign addr_err = err_q;
`else
    // Without the check the upper word bits simply wrap around the SRAM.
    assign in_range = 1'b1;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_cnt (
        .clk(clk),
        .rst(rst),
        .clr(~in_phase | tc),
        .en (in_phase),
        .tc (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            low_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            low_q    <= low_d;
            result_q <= result_d;
        end
    end

`ifdef MEM_RANGE_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_d = err_q | ((state_q == ST_IDLE) & req & ~in_range);
`endif

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        data_d   = data_q;
        wr_d     = wr_q;
        low_d    = low_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (in_range) begin
                        word_d  = word_full[WORD_W-1:0];
                        data_d  = val_rm;
                        wr_d    = mem_w_en;
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOW: begin
                if (tc) begin
                    if (!wr_q) low_d = sram_dq_in;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                // Result is committed on the exit edge so it is stable for all of DONE.
                if (tc) begin
                    if (!wr_q) result_d = {sram_dq_in, low_q};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b1;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state_q)
            ST_IDLE: ready = ~req;
            ST_LOW: begin
                ready     = 1'b0;
                sram_addr = {word_q, 1'b0};
                if (wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                    sram_dq_out = data_q[15:0];
                end
            end
            ST_HIGH: begin
                ready     = 1'b0;
                sram_addr = {word_q, 1'b1};
                if (wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                    sram_dq_out = data_q[31:16];
                end
            end
            default: ready = 1'b1;
        endcase
    end

    assign mem_result = result_q;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Randomized bench for mem_stage_sram: three instances (WAIT_CYCLES 1, 0, 3) against an SRAM model.
module tb_mem_stage_sram;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_mem;
    logic        r_en [N];
    logic        w_en [N];
    logic [31:0] alu  [N];
    logic [31:0] rm   [N];
    logic        rdy  [N];
    logic [31:0] mres [N];
    logic [17:0] saddr[N];
    logic [15:0] dqo  [N];
    logic [15:0] dqi  [N];
    logic        oe   [N];
    logic        wen  [N];
`ifdef MEM_RANGE_CHECK_EN
    logic        aerr [N];
`endif

    logic [15:0] sram    [N][256];
    logic [15:0] ref_mem [N][256];
    logic [31:0] exp_res [N];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        mem_stage_sram #(
            .BASE_ADDR(1024),
            .SRAM_ADDR_W(18),
            .WAIT_CYCLES(WC)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .mem_r_en   (r_en[g]),
            .mem_w_en   (w_en[g]),
            .alu_res    (alu[g]),
            .val_rm     (rm[g]),
            .ready      (rdy[g]),
            .mem_result (mres[g]),
            .sram_addr  (saddr[g]),
            .sram_dq_out(dqo[g]),
            .sram_dq_in (dqi[g]),
            .sram_dq_oe (oe[g]),
            .sram_we_n  (wen[g])
`ifdef MEM_RANGE_CHECK_EN
            ,
            .addr_err   (aerr[g])
`endif
        );
    end

    // Synchronous SRAM model, 256 half-words per instance.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (init_mem) begin
                for (int i = 0; i < 256; i++) sram[k][i] <= ref_mem[k][i];
            end else if (!wen[k]) begin
                sram[k][saddr[k][7:0]] <= dqo[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) dqi[k] = sram[k][saddr[k][7:0]];
    end

    function automatic int wc_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input int k, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] data);
        int          wc, exp_stall, stall, we_cnt, seq_bad, oe_bad;
        bit          in_range, done, is_wr;
        logic [31:0] word, mr;
        logic [17:0] lo_a, hi_a, exp_a;
        logic [15:0] exp_dq;
        wc       = wc_of(k);
        is_wr    = wr;
        word     = (addr - 32'd1024) >> 2;
        lo_a     = 18'((word * 2) % (32'd1 << 18));
        hi_a     = lo_a + 18'd1;
        in_range = 1'b1;
`ifdef MEM_RANGE_CHECK_EN
        in_range = (addr >= 32'd1024) && (word < (32'd1 << 17));
`endif
        exp_stall = in_range ? 2 * wc + 3 : 1;
        stall = 0; we_cnt = 0; seq_bad = 0; oe_bad = 0; done = 1'b0; mr = '0;
        @(negedge clk);
        r_en[k] = rd; w_en[k] = wr; alu[k] = addr; rm[k] = data;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rdy[k]) begin
                done = 1'b1;
                mr   = mres[k];
                break;
            end
            stall++;
            if (!wen[k]) begin
                we_cnt++;
                if (!oe[k]) oe_bad++;
            end
            if (i >= 1 && in_range && i <= 2 * wc + 2) begin
                exp_a  = (i - 1 < wc + 1) ? lo_a : hi_a;
                exp_dq = (i - 1 < wc + 1) ? data[15:0] : data[31:16];
                if (saddr[k] !== exp_a) seq_bad++;
                if (is_wr && dqo[k] !== exp_dq) seq_bad++;
            end
            @(negedge clk);
            if (i + 1 >= exp_stall) begin
                r_en[k] = 1'b0; w_en[k] = 1'b0;
            end else begin
                r_en[k] = 1'($urandom); w_en[k] = 1'($urandom);
                alu[k]  = $urandom;     rm[k]   = $urandom;
            end
        end
        check("txn_done", done, 1);
        check("stall_len", stall, exp_stall);
        check("we_cycles", we_cnt, (is_wr && in_range) ? 2 * (wc + 1) : 0);
        check("addr_seq", seq_bad, 0);
        check("we_without_oe", oe_bad, 0);
        if (in_range && is_wr) begin
            ref_mem[k][lo_a[7:0]] = data[15:0];
            ref_mem[k][hi_a[7:0]] = data[31:16];
            check("sram_lo", sram[k][lo_a[7:0]], data[15:0]);
            check("sram_hi", sram[k][hi_a[7:0]], data[31:16]);
        end else if (in_range && rd) begin
            exp_res[k] = {ref_mem[k][hi_a[7:0]], ref_mem[k][lo_a[7:0]]};
        end
        check("mem_result", mr, exp_res[k]);
`ifdef MEM_RANGE_CHECK_EN
        if (!in_range) check("addr_err", aerr[k], 1);
`endif
    endtask

    initial begin
        logic [15:0] old3;
        int          k, gap;
        bit          rd, wr;
        logic [31:0] a;
        rst = 1'b1;
        init_mem = 1'b1;
        for (int j = 0; j < N; j++) begin
            r_en[j] = 1'b0; w_en[j] = 1'b0; alu[j] = '0; rm[j] = '0; exp_res[j] = '0;
            for (int i = 0; i < 256; i++) ref_mem[j][i] = 16'($urandom);
        end
        @(negedge clk);
        init_mem = 1'b0;
        #1;
        check("rst_ready", rdy[0], 1);
        check("rst_mem_result", mres[0], 0);
        check("rst_sram_addr", saddr[0], 0);
        check("rst_dq_out", dqo[0], 0);
        check("rst_dq_oe", oe[0], 0);
        check("rst_we_n", wen[0], 1);
`ifdef MEM_RANGE_CHECK_EN
        check("rst_addr_err", aerr[0], 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_txn(0, 0, 1, 32'd1024, 32'h12345678);
        run_txn(0, 1, 0, 32'd1024, 32'h0);
        check("load_1024", exp_res[0], 32'h12345678);
        run_txn(0, 0, 1, 32'd1028, 32'hCAFEBEEF);
        run_txn(0, 1, 0, 32'd1031, 32'h0);
        run_txn(1, 1, 1, 32'd1040, 32'hA5A55A5A);
        run_txn(1, 1, 0, 32'd1040, 32'h0);
        run_txn(2, 1, 1, 32'd1100, 32'h0F0F1234);
        run_txn(2, 1, 0, 32'd1100, 32'h0);
`ifdef MEM_RANGE_CHECK_EN
        run_txn(0, 0, 1, 32'd512, 32'hDEADBEEF);
        run_txn(0, 1, 0, 32'd1024 + (32'd4 << 17), 32'h0);
        run_txn(0, 1, 0, 32'd1028, 32'h0);
        check("addr_err_sticky", aerr[0], 1);
`else
        run_txn(0, 0, 1, 32'd1024 + 4 * ((32'd1 << 17) + 5), 32'h77665544);
        run_txn(0, 1, 0, 32'd1044, 32'h0);
`endif

        for (int t = 0; t < 60; t++) begin
            k  = int'($urandom_range(0, N - 1));
            wr = 1'($urandom);
            rd = wr ? 1'($urandom) : 1'b1;
            a  = 32'd1024 + 4 * $urandom_range(0, 127) + $urandom_range(0, 3);
            run_txn(k, rd, wr, a, $urandom);
            gap = int'($urandom_range(0, 2));
            for (int g2 = 0; g2 < gap; g2++) begin
                @(negedge clk);
                #1;
                check("idle_hold", mres[k], exp_res[k]);
            end
        end

        // Reset during the high half of a store must abort it.
        old3 = ref_mem[0][3];
        @(negedge clk);
        w_en[0] = 1'b1; alu[0] = 32'd1028; rm[0] = 32'h0BADF00D;
        @(negedge clk);
        w_en[0] = 1'b0; alu[0] = '0; rm[0] = '0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_rst_we_n", wen[0], 0);
        check("pre_rst_addr", saddr[0], 3);
        rst = 1'b1;
        #1;
        check("mid_rst_we_n", wen[0], 1);
        check("mid_rst_oe", oe[0], 0);
        check("mid_rst_ready", rdy[0], 1);
        check("mid_rst_mem_result", mres[0], 0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < N; j++) exp_res[j] = '0;
        ref_mem[0][2] = 16'hF00D;
        repeat (2) @(negedge clk);
        check("rst_sram3_kept", sram[0][3], old3);
        check("rst_sram2_low", sram[0][2], 16'hF00D);
`ifdef MEM_RANGE_CHECK_EN
        check("addr_err_cleared", aerr[0], 0);
`endif
        run_txn(0, 1, 0, 32'd1028, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
